sine_pwm_dds: RTL and testbench
===============================

Name: sine_pwm_dds

Overview:
- Parametrised successor to the fixed 8-bit sine PWM generator.
- Sine samples come from a phase accumulator (DDS) driving a quarter-wave LUT, with programmable frequency (phase step) and amplitude.
- Each sample is emitted as offset-binary data and as a PWM duty on a free-running period counter.
- Adds enable/drain control and glitch-free, period-aligned configuration updates.

Parameters:
- DATA_W, 8, sample width (offset binary), >=4
- PWM_W, 8, PWM counter width; 2 <= PWM_W <= DATA_W
- PHASE_W, 16, phase accumulator width
- LUT_AW, 6, quarter-wave LUT address width; LUT has 2^LUT_AW+1 entries; LUT_AW+2 <= PHASE_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request
- cfg_load  in  1  one-cycle strobe: capture phase_step/amplitude into shadow regs
- phase_step  in  PHASE_W  accumulator increment per PWM period
- amplitude  in  8  scale; effective gain (amplitude+1)/256
- pwm  out  1  PWM output
- sin_reg  out  DATA_W  current sine sample, offset binary
- update_c  out  PWM_W  PWM period counter
- sample_strobe  out  1  one-cycle pulse when a new duty is loaded

Behaviour:
- Reset (synchronous, active-high; all state including shadow and active config):
  - state=IDLE, acc=0, update_c=0, pwm=0, sample_strobe=0.
  - sin_reg=duty=2^(DATA_W-1); all config regs = 0.
- LUT:
  - m(k)=round((2^(DATA_W-1)-1)*sin(pi/2*k/2^LUT_AW)), k=0..2^LUT_AW.
  - m(0)=0; m(2^LUT_AW)=2^(DATA_W-1)-1.
- Phase decode:
  - q = acc[PHASE_W-1 -: 2]; i = acc[PHASE_W-3 -: LUT_AW].
  - q0: s=+m(i); q1: s=+m(2^LUT_AW-i); q2: s=-m(i); q3: s=-m(2^LUT_AW-i).
- Scaling:
  - scaled = (s*(amplitude+1)) >>> 8, arithmetic, floor.
  - sin_reg = scaled + 2^(DATA_W-1), never wraps.
- Pipeline:
  - Two registered stages: LUT, then scale/offset.
  - sin_reg reflects acc two cycles after acc changes.
  - acc changes at most once per 2^PWM_W >= 4 cycles, so sin_reg is stable before the next use.
- Period:
  - update_c counts 0..2^PWM_W-1 and wraps in RUN/DRAIN; held at 0 in IDLE.
  - "wrap cycle" = update_c==2^PWM_W-1 in RUN/DRAIN.
- At the wrap cycle (registered on that edge):
  - duty <= duty field of sin_reg, i.e. sin_reg[DATA_W-1 -: PWM_W].
  - acc <= acc + active_step, modulo 2^PHASE_W.
  - active_step/active_amp <= shadow values if a cfg_load is pending; pending cleared.
  - sample_strobe=1 on the following cycle.
- Duty timing: a phase value drives pwm in the period after the one in which it was computed.
- Output: pwm = (state!=IDLE) && (update_c < duty), registered, one cycle latency from update_c.
- cfg_load:
  - Captures inputs into shadow regs and sets pending.
  - In IDLE it also copies straight to active.
  - A second cfg_load before the wrap overwrites the shadow (last wins).
  - cfg_load coincident with the wrap cycle: the new values are applied at that wrap.
- FSM transitions:
  - IDLE: enable=1 -> RUN; first period starts with update_c=0 next cycle.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: completes the current period, wrap actions included, then -> IDLE. enable=1 during DRAIN -> RUN with no break in update_c.
  - acc is held in IDLE; restart continues from the held phase.
- reset mid-period: immediate return to reset values; no drain.

Test Plan:
- Reset, then enable=1 with cfg 0 -> pwm high exactly 128 of every 256 cycles; sin_reg=128; acc stays 0; sample_strobe every 256 cycles.
- IDLE cfg_load phase_step=0x4000, amplitude=255, enable -> per-period duties 128,128,255,128,1,128,255,...; pwm high counts match the duties; sin_reg steps 128->255->128->1.
- Mid-period cfg_load amplitude=127 while running -> duties unchanged until the next wrap. Afterwards peak sin_reg=128+63=191 and trough 128-64=64.
- Drop enable at update_c=10 -> pwm continues to update_c=255, one strobe, then IDLE. pwm=0 and update_c=0 held; re-enable resumes from the held acc.
- Re-assert enable during DRAIN at update_c=200 -> no gap; update_c wraps 255->0 and stays RUN.
- Assert reset at update_c=100 in RUN -> next cycle: pwm=0, update_c=0, sin_reg=128, state IDLE, config cleared.

Source files
------------

// File: rtl/sine_pwm_dds.sv
// sine_pwm_dds: DDS sine generator with a quarter-wave LUT, amplitude scaling
// and PWM output on a free-running period counter.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   enable         : run request (dropping it drains the current period)
//   cfg_load       : strobe capturing phase_step/amplitude into shadow regs
//   phase_step     : accumulator increment applied once per PWM period
//   amplitude      : gain (amplitude+1)/256
//   pwm            : registered PWM output
//   sin_reg        : current sine sample, offset binary
//   update_c       : PWM period counter
//   sample_strobe  : one-cycle pulse after a new duty is loaded
module sine_pwm_dds #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PWM_W   = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] phase_step,
  input  logic [7:0]         amplitude,
  output logic               pwm,
  output logic [DATA_W-1:0]  sin_reg,
  output logic [PWM_W-1:0]   update_c,
  output logic               sample_strobe
);

  localparam int unsigned MAG_W  = DATA_W - 1;
  localparam int unsigned ADDR_W = LUT_AW + 1;
  localparam int unsigned PROD_W = DATA_W + 9;
  localparam logic [PWM_W-1:0]  PWM_MAX  = '1;
  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [PWM_W-1:0]  DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] LUT_TOP  = {1'b1, {LUT_AW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  // Quarter-wave magnitude, rounded to nearest; evaluated at elaboration.
  function automatic int sine_mag(input int k);
    real full;
    real ang;
    full = real'((1 << (DATA_W - 1)) - 1);
    ang  = 3.14159265358979 / 2.0 * real'(k) / real'(1 << LUT_AW);
    return $rtoi(full * $sin(ang) + 0.5);
  endfunction

  logic [MAG_W-1:0] lut_rom [(1 << LUT_AW) + 1];

  for (genvar g = 0; g <= (1 << LUT_AW); g++) begin : g_lut
    assign lut_rom[g] = MAG_W'(sine_mag(g));
  end

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PWM_W-1:0]   update_c_q, update_c_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic               pwm_q, pwm_d;
  logic               strobe_q, strobe_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic [DATA_W-1:0]  sin_q, sin_d;
  logic [PHASE_W-1:0] shadow_step_q, shadow_step_d;
  logic [7:0]         shadow_amp_q, shadow_amp_d;
  logic [PHASE_W-1:0] active_step_q, active_step_d;
  logic [7:0]         active_amp_q, active_amp_d;
  logic               pending_q, pending_d;

  logic                     wrap;
  logic [1:0]               quad;
  logic [LUT_AW-1:0]        idx;
  logic [ADDR_W-1:0]        addr;
  logic [8:0]               gain;
  logic signed [DATA_W-1:0] s_val;
  logic signed [PROD_W-1:0] s_w, g_w, prod;

  // Control, period counter, config handling and datapath next-state.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    update_c_d    = update_c_q;
    duty_d        = duty_q;
    shadow_step_d = shadow_step_q;
    shadow_amp_d  = shadow_amp_q;
    active_step_d = active_step_q;
    active_amp_d  = active_amp_q;
    pending_d     = pending_q;

    wrap = (state_q != ST_IDLE) && (update_c_q == PWM_MAX);

    unique case (state_q)
      ST_IDLE: begin
        update_c_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        update_c_d = update_c_q + PWM_W'(1);
        if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        update_c_d = update_c_q + PWM_W'(1);
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        update_c_d = '0;
      end
    endcase

    if (cfg_load) begin
      shadow_step_d = phase_step;
      shadow_amp_d  = amplitude;
      pending_d     = 1'b1;
      // While idle there is no running period to protect.
      if (state_q == ST_IDLE) begin
        active_step_d = phase_step;
        active_amp_d  = amplitude;
      end
    end

    if (wrap) begin
      duty_d = sin_q[DATA_W-1 -: PWM_W];
      acc_d  = acc_q + active_step_q;
      // A load landing on the wrap cycle itself takes effect at this wrap.
      if (cfg_load) begin
        active_step_d = phase_step;
        active_amp_d  = amplitude;
        pending_d     = 1'b0;
      end else if (pending_q) begin
        active_step_d = shadow_step_q;
        active_amp_d  = shadow_amp_q;
        pending_d     = 1'b0;
      end
    end

    strobe_d = wrap;
    pwm_d    = (state_q != ST_IDLE) && (update_c_q < duty_q);

    // Stage 1: quadrant fold and LUT lookup.
    quad  = acc_q[PHASE_W-1 -: 2];
    idx   = acc_q[PHASE_W-3 -: LUT_AW];
    addr  = quad[0] ? (LUT_TOP - {1'b0, idx}) : {1'b0, idx};
    mag_d = lut_rom[addr];
    neg_d = quad[1];

    // Stage 2: signed scale (floor) and offset to binary.
    s_val = $signed({1'b0, mag_q});
    if (neg_q) s_val = -s_val;
    gain  = 9'(active_amp_q) + 9'd1;
    s_w   = PROD_W'(s_val);
    g_w   = PROD_W'(gain);
    prod  = s_w * g_w;
    sin_d = DATA_W'(prod >>> 8) + MID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      update_c_q    <= '0;
      duty_q        <= DUTY_MID;
      pwm_q         <= 1'b0;
      strobe_q      <= 1'b0;
      mag_q         <= '0;
      neg_q         <= 1'b0;
      sin_q         <= MID;
      shadow_step_q <= '0;
      shadow_amp_q  <= '0;
      active_step_q <= '0;
      active_amp_q  <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      update_c_q    <= update_c_d;
      duty_q        <= duty_d;
      pwm_q         <= pwm_d;
      strobe_q      <= strobe_d;
      mag_q         <= mag_d;
      neg_q         <= neg_d;
      sin_q         <= sin_d;
      shadow_step_q <= shadow_step_d;
      shadow_amp_q  <= shadow_amp_d;
      active_step_q <= active_step_d;
      active_amp_q  <= active_amp_d;
      pending_q     <= pending_d;
    end
  end

  assign pwm           = pwm_q;
  assign sin_reg       = sin_q;
  assign update_c      = update_c_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_sine_pwm_dds.sv
// Directed bench for sine_pwm_dds at default parameters: per-period table of
// expected duty (pwm high count), mid-period sine sample and wrap strobe, plus
// hand sequences for drain, drain cancel and mid-period reset.
module tb_sine_pwm_dds;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cfg_load;
  logic [15:0] phase_step;
  logic [7:0]  amplitude;
  logic        pwm;
  logic [7:0]  sin_reg;
  logic [7:0]  update_c;
  logic        sample_strobe;

  int total = 0;
  int bad   = 0;

  sine_pwm_dds dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cfg_load      (cfg_load),
    .phase_step    (phase_step),
    .amplitude     (amplitude),
    .pwm           (pwm),
    .sin_reg       (sin_reg),
    .update_c      (update_c),
    .sample_strobe (sample_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;      // cfg_load at update_c==50 of this period
    logic [15:0] step;
    logic [7:0]  amp;
    logic        exp_strobe; // strobe seen at update_c==0 of this period
    int          exp_high;   // pwm high cycles for this period
    int          exp_sin;    // sin_reg sampled at update_c==128
  } period_vec_t;

  period_vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts on a sample with update_c==0; ends on the next period's update_c==0.
  task automatic run_period(input period_vec_t v, input string tag);
    int high;
    int mid;
    high = 0;
    mid  = -1;
    check({tag, "_start_cnt"}, int'(update_c), 0);
    check({tag, "_strobe"}, int'(sample_strobe), int'(v.exp_strobe));
    for (int c = 0; c < 256; c++) begin
      if (v.load && update_c == 8'd50) begin
        cfg_load   = 1'b1;
        phase_step = v.step;
        amplitude  = v.amp;
      end
      tick();
      cfg_load = 1'b0;
      high += int'(pwm);
      if (update_c == 8'd128) mid = int'(sin_reg);
    end
    check({tag, "_high"}, high, v.exp_high);
    check({tag, "_sin"}, mid, v.exp_sin);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pwm"}, int'(pwm), 0);
    check({tag, "_cnt"}, int'(update_c), 0);
    check({tag, "_sin"}, int'(sin_reg), 128);
    check({tag, "_strobe"}, int'(sample_strobe), 0);
  endtask

  initial begin
    int high;
    int strobes;
    int errs;
    int guard;
    logic [7:0] prev;

    //             load  step     amp  strobe high sin
    vecs[0]  = '{1'b0, 16'h0, 8'd0,   1'b0, 128, 128};
    vecs[1]  = '{1'b0, 16'h0, 8'd0,   1'b1, 128, 255};
    vecs[2]  = '{1'b0, 16'h0, 8'd0,   1'b1, 255, 128};
    vecs[3]  = '{1'b0, 16'h0, 8'd0,   1'b1, 128, 1};
    vecs[4]  = '{1'b0, 16'h0, 8'd0,   1'b1, 1,   128};
    vecs[5]  = '{1'b0, 16'h0, 8'd0,   1'b1, 128, 255};
    vecs[6]  = '{1'b0, 16'h0, 8'd0,   1'b1, 255, 128};
    vecs[7]  = '{1'b1, 16'h4000, 8'd127, 1'b1, 128, 1};
    vecs[8]  = '{1'b0, 16'h0, 8'd0,   1'b1, 1,   128};
    vecs[9]  = '{1'b0, 16'h0, 8'd0,   1'b1, 128, 191};
    vecs[10] = '{1'b0, 16'h0, 8'd0,   1'b1, 191, 128};
    vecs[11] = '{1'b0, 16'h0, 8'd0,   1'b1, 128, 64};
    vecs[12] = '{1'b0, 16'h0, 8'd0,   1'b1, 64,  128};

    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    phase_step = '0; amplitude = '0;
    tick(); tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // Default config: flat midscale, 50% duty.
    enable = 1'b1;
    tick();
    run_period('{1'b0, 16'h0, 8'd0, 1'b0, 128, 128}, "cfg0_p1");
    run_period('{1'b0, 16'h0, 8'd0, 1'b1, 128, 128}, "cfg0_p2");
    run_period('{1'b0, 16'h0, 8'd0, 1'b1, 128, 128}, "cfg0_p3");

    // Quarter-cycle step, full amplitude, loaded while idle.
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    cfg_load = 1'b1; phase_step = 16'h4000; amplitude = 8'd255;
    tick();
    cfg_load = 1'b0;
    enable = 1'b1;
    tick();
    foreach (vecs[i]) run_period(vecs[i], $sformatf("vec%0d", i));

    // Drain: drop enable at update_c==10 of a 128-duty period.
    check("drain_strobe0", int'(sample_strobe), 1);
    high = 0;
    repeat (10) begin tick(); high += int'(pwm); end
    check("drain_at10", int'(update_c), 10);
    enable = 1'b0;
    strobes = 0;
    guard = 0;
    do begin
      tick();
      high += int'(pwm);
      strobes += int'(sample_strobe);
      guard++;
    end while (update_c != 8'd0 && guard < 400);
    check("drain_bound", guard, 246);
    check("drain_high", high, 128);
    check("drain_strobes", strobes, 1);
    errs = 0;
    repeat (20) begin
      tick();
      if (pwm !== 1'b0 || update_c !== 8'd0 || sample_strobe !== 1'b0) errs++;
    end
    check("idle_hold_errs", errs, 0);
    check("idle_sin", int'(sin_reg), 128);

    // Restart continues from the held phase (0x8000).
    enable = 1'b1;
    tick();
    run_period('{1'b0, 16'h0, 8'd0, 1'b0, 191, 128}, "resume_p1");
    run_period('{1'b0, 16'h0, 8'd0, 1'b1, 128, 64}, "resume_p2");

    // Drain cancelled at update_c==200: counter must not break.
    high = 0;
    errs = 0;
    for (int c = 0; c < 256; c++) begin
      if (update_c == 8'd100) enable = 1'b0;
      if (update_c == 8'd200) enable = 1'b1;
      prev = update_c;
      tick();
      high += int'(pwm);
      if (update_c !== 8'(prev + 8'd1)) errs++;
    end
    check("cancel_gap_errs", errs, 0);
    check("cancel_high", high, 64);
    run_period('{1'b0, 16'h0, 8'd0, 1'b1, 128, 191}, "cancel_next");

    // Reset in the middle of a running period.
    repeat (100) tick();
    check("midrst_at100", int'(update_c), 100);
    check("midrst_pwm_before", int'(pwm), 1);
    reset = 1'b1; enable = 1'b0;
    tick();
    check_reset_state("midrst");
    reset = 1'b0;
    repeat (5) tick();
    check("midrst_idle_cnt", int'(update_c), 0);
    check("midrst_idle_pwm", int'(pwm), 0);
    enable = 1'b1;
    tick();
    run_period('{1'b0, 16'h0, 8'd0, 1'b0, 128, 128}, "cleared_p1");
    run_period('{1'b0, 16'h0, 8'd0, 1'b1, 128, 128}, "cleared_p2");
    run_period('{1'b0, 16'h0, 8'd0, 1'b1, 128, 128}, "cleared_p3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
